// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// One register stage of a valid/ready pipeline, such as the EX/MEM boundary.
// It holds one payload in a main register that drives out_data straight from a
// flop. The stage can run one payload per cycle with a latency of exactly one
// cycle. flush squashes every payload the stage holds. A saturating counter
// records how many cycles the downstream stage has stalled.
//
// Build option:
//   PIPE_STAGE_SKID_EN  undefined (default): in_ready is computed
//                       combinationally from out_ready. There is no skid
//                       register.
//                       defined: a second (skid) register catches the one
//                       payload that can arrive while the stage is blocked.
//                       in_ready then comes from a flop, so no combinational
//                       path runs from out_ready to in_ready.
//
// Parameters:
//   WIDTH      payload width in bits (41 = full EX/MEM bundle)
//   RESET_VAL  payload value loaded into the main register on reset
//   CNT_W      stall counter width
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   flush      squash all held payloads; has priority over every other event
//   in_valid   upstream offers in_data
//   in_ready   this stage accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid payload
//   out_ready  downstream consumes out_data this cycle
//   out_data   registered payload to downstream
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
//   stall_clr  synchronous clear of stall_cnt (wins over increment)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 41,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  // Main register. out_data comes directly from this flop.
  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic in_fire;
  logic out_fire;

  assign out_fire = valid_reg && out_ready;
  assign in_fire  = in_valid && in_ready;

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign stall_cnt = stall_cnt_reg;

`ifdef PIPE_STAGE_SKID_EN

  // Skid register. It can only be valid while the main register is valid.
  logic             skid_valid_reg;
  logic [WIDTH-1:0] skid_data_reg;
  // Registered copy of !skid_valid_reg. This keeps out_ready off the
  // in_ready timing path.
  logic             ready_reg;

  // flush empties both registers at the coming edge, so anything offered in
  // that cycle may be "accepted" and then dropped. This stops upstream from
  // stalling on a payload that is being squashed anyway.
  assign in_ready = ready_reg || flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      data_reg       <= RESET_VAL;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= RESET_VAL;
      ready_reg      <= 1'b1;
    end else if (flush) begin
      // Clear only the valid bits. out_data keeps its last value.
      valid_reg      <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else if (skid_valid_reg) begin
      // in_ready is low here, so nothing new can arrive. Move the skid
      // payload forward when the main payload leaves.
      if (out_fire) begin
        data_reg       <= skid_data_reg;
        skid_valid_reg <= 1'b0;
        ready_reg      <= 1'b1;
      end
    end else if (in_fire) begin
      if (!valid_reg || out_fire) begin
        // Main register is empty or draining: load it directly.
        data_reg  <= in_data;
        valid_reg <= 1'b1;
      end else begin
        // Main register is blocked: park the payload and close the input.
        skid_data_reg  <= in_data;
        skid_valid_reg <= 1'b1;
        ready_reg      <= 1'b0;
      end
    end else if (out_fire) begin
      valid_reg <= 1'b0;
    end
  end

`else

  // The main register can take a payload whenever it is empty or draining.
  // flush empties it regardless.
  assign in_ready = flush || out_ready || !valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= RESET_VAL;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (in_fire) begin
      // in_ready guarantees the old payload is leaving or absent.
      data_reg  <= in_data;
      valid_reg <= 1'b1;
    end else if (out_fire) begin
      valid_reg <= 1'b0;
    end
  end

`endif

  // Stall counter: counts cycles where a valid payload waits on downstream.
  // It saturates at all-ones and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall_clr) begin
      stall_cnt_reg <= '0;
    end else if (valid_reg && !out_ready && !flush &&
                 (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed testbench for pipe_stage_reg. It covers reset, streaming,
// backpressure, flush, stall counter saturation and clear, and asynchronous
// reset in the middle of a stall.
//
// Two instances share the same stimulus:
//   dut    default parameters (CNT_W = 16)
//   u_sat  CNT_W = 4, used only to check saturation of stall_cnt
//
// Steps that only apply to the skid build are wrapped in
// `ifdef PIPE_STAGE_SKID_EN.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int W = 41;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [15:0]   stall_cnt;
  logic          stall_clr;

  logic          sat_in_ready;
  logic          sat_out_valid;
  logic [W-1:0]  sat_out_data;
  logic [3:0]    sat_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  pipe_stage_reg #(.CNT_W(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_data   (in_data),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_data  (sat_out_data),
    .stall_cnt (sat_stall_cnt),
    .stall_clr (stall_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge, then sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 41'h1_2345_6789A;
    out_ready = 1'b1;
    stall_clr = 1'b0;

    // ---------------- Reset held with input offered ----------------
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      step();
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    $display("reset: held 3 cycles, released");

    // ---------------- Streaming 1..8 ----------------
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      #1;
      chk("stream_in_ready", in_ready, 1);
      step();
      chk("stream_out_valid", out_valid, 1);
      chk("stream_out_data", out_data, i);
      $display("stream: sent %0d, out_data=%0d", i, out_data);
    end
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_hold_data", out_data, 8);
    chk("stream_no_stall", stall_cnt, 0);

    // ---------------- Backpressure with 0xAA ----------------
    in_valid = 1'b1;
    in_data  = W'('hAA);
    step();
    chk("bp_load_valid", out_valid, 1);
    chk("bp_load_data", out_data, 'hAA);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("bp_hold_data", out_data, 'hAA);
      chk("bp_hold_valid", out_valid, 1);
      $display("backpressure: cycle %0d out_data=0x%0h stall_cnt=%0d", i, out_data, stall_cnt);
    end
    chk("bp_stall_cnt", stall_cnt, 5);
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_skid_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = W'('hBB);
    step();
    in_valid = 1'b0;
    chk("bp_skid_full_ready", in_ready, 0);
    chk("bp_skid_main_data", out_data, 'hAA);
    out_ready = 1'b1;
    #1;
    chk("bp_emit_aa", out_data, 'hAA);
    step();
    chk("bp_emit_bb_valid", out_valid, 1);
    chk("bp_emit_bb", out_data, 'hBB);
    chk("bp_skid_ready_back", in_ready, 1);
    step();
    chk("bp_empty_after_bb", out_valid, 0);
`else
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", in_ready, 1);
    chk("bp_emit_aa", out_data, 'hAA);
    step();
    chk("bp_empty_after_aa", out_valid, 0);
`endif
    $display("backpressure: released");

    // ---------------- Flush ----------------
    in_valid = 1'b1;
    in_data  = W'('hAA);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b1;
    in_data  = W'('hBB);
    step();
`endif
    chk("fl_pre_valid", out_valid, 1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = W'('hCC);
    #1;
    chk("fl_in_ready", in_ready, 1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_data_held", out_data, 'hAA);
    out_ready = 1'b1;
    step();
    chk("fl_still_empty", out_valid, 0);
    step();
    chk("fl_still_empty2", out_valid, 0);
    $display("flush: out_valid=%0d after flush", out_valid);

    // ---------------- Stall counter clear and saturation ----------------
    in_valid = 1'b1;
    in_data  = W'(5);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("clr_dut", stall_cnt, 0);
    chk("clr_sat", sat_stall_cnt, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt4", sat_stall_cnt, 15);
    chk("sat_cnt16", stall_cnt, 20);
    $display("saturation: cnt4=%0d cnt16=%0d", sat_stall_cnt, stall_cnt);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("clr_active_sat", sat_stall_cnt, 0);
    chk("clr_active_dut", stall_cnt, 0);
    chk("clr_still_valid", out_valid, 1);

    // ---------------- Asynchronous reset mid-stall ----------------
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_stall_cnt", stall_cnt, 0);
    chk("async_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    #1;
    chk("async_rel_in_ready", in_ready, 1);
    chk("async_rel_valid", out_valid, 0);
    $display("async reset: out_valid=%0d before next edge", out_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 41, SHALL set the payload width in bits (41 = full EX/MEM bundle: address 16, ReadMem 1, WriteMem 1, quarter 2, DataIn 16, write 1, writeReg 4).
REQ-002 Parameter RESET_VAL, default 0, WIDTH bits, SHALL be the payload value loaded at reset.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  kills all held entries (branch/exception squash).
REQ-007 in_valid  input  1  upstream stage presents a valid payload.
REQ-008 in_ready  output  1  this stage accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid payload.
REQ-011 out_ready  input  1  downstream stage consumes out_data this cycle.
REQ-012 out_data  output  WIDTH  registered payload to downstream.
REQ-013 stall_cnt  output  CNT_W  saturating count of downstream-stall cycles.
REQ-014 stall_clr  input  1  synchronous clear of stall_cnt.

Function
REQ-015 A transfer in SHALL occur on a rising edge where in_valid && in_ready; a transfer out SHALL occur where out_valid && out_ready.
REQ-016 Latency SHALL be exactly one cycle: a payload accepted at edge N SHALL appear on out_data with out_valid=1 after edge N when the stage was empty or draining.
REQ-017 out_data SHALL come directly from a flop; with out_valid=0 it SHALL hold its last value.
REQ-018 The stage SHALL never drop, duplicate or reorder payloads while flush=0.
REQ-019 Simultaneous transfer in and transfer out on one edge SHALL replace the main entry with the new payload, keeping out_valid=1 (full throughput, one payload per cycle).
REQ-020 Transfer out with no transfer in (and no skid entry) SHALL clear out_valid.
REQ-021 flush=1 at an edge SHALL clear out_valid and any skid entry; a payload offered in that same cycle SHALL be discarded; flush SHALL take priority over every other event.
REQ-022 in_ready SHALL be 1 while flush=1.
REQ-023 stall_cnt SHALL increment by 1 on each edge with out_valid=1 && out_ready=0 && flush=0, saturate at 2^CNT_W-1, and never wrap.
REQ-024 stall_clr=1 SHALL zero stall_cnt on that edge, taking priority over increment.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force out_valid=0, out_data=RESET_VAL, skid entry invalid, stall_cnt=0.
REQ-026 in_ready SHALL be 1 during reset and on the first cycle after release.
REQ-027 Reset asserted mid-transfer SHALL discard all held payloads; no partial state SHALL survive.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN SHALL select the ready-path structure.
REQ-029 Without PIPE_STAGE_SKID_EN: in_ready = out_ready || !out_valid (combinational from out_ready); no skid register.
REQ-030 With PIPE_STAGE_SKID_EN: in_ready SHALL be a flop output, equal to !skid_valid, with no combinational path from out_ready.
REQ-031 With skid: transfer in while out_valid=1 and out_ready=0 SHALL store the payload in the skid register, set skid_valid, and drop in_ready on the next cycle.
REQ-032 With skid: transfer out while skid_valid=1 SHALL move skid to main (out_valid stays 1), clear skid_valid, and raise in_ready on the next cycle.
REQ-033 Both builds SHALL give identical cycle-level out_valid/out_data sequences for any stimulus where in_valid=0 whenever non-skid in_ready=0.

Verification
REQ-034 Reset: hold rst_n=0 with in_valid=1, in_data=0x1_2345_6789A -> out_valid=0, out_data=RESET_VAL, stall_cnt=0, in_ready=1 throughout.
REQ-035 Streaming: out_ready=1, in_valid=1 for payloads 1..8 on consecutive cycles -> out_data shows 1..8 on consecutive cycles after one-cycle latency, no bubbles.
REQ-036 Backpressure: out_ready=0 for 5 cycles with payload 0xAA held -> out_data=0xAA stable, stall_cnt=5; skid build accepts one extra payload 0xBB then in_ready=0; on out_ready=1 emits 0xAA then 0xBB.
REQ-037 Flush: flush=1 coincident with in_valid=1, in_data=0xCC while holding 0xAA (and skid 0xBB) -> next cycle out_valid=0; 0xAA, 0xBB, 0xCC never transferred out.
REQ-038 Counter saturation: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt stops at 15; stall_clr=1 with stall active -> stall_cnt=0 next cycle.
REQ-039 Async reset mid-stall: rst_n low between edges with out_valid=1 -> out_valid=0 before the next rising edge.
